// File: rtl/pwm_multi_shadow_if.sv
// pwm_multi_shadow_if
//   Register-write bus from the Nios II side into the PWM block.
//   wr_en   : one write per cycle
//   wr_addr : 0..NUM_CH-1 = duty shadow of that channel, NUM_CH = period shadow
//   wr_data : value for the selected shadow register
//   master drives the bus (CPU side / bench), slave receives it (PWM block).
interface pwm_multi_shadow_if #(
  parameter int NUM_CH = 9,
  parameter int RES    = 16,
  parameter int AW     = $clog2(NUM_CH + 1)
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RES-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_multi_shadow.sv
// pwm_multi_shadow
//   Multi-channel PWM generator with one shared period counter and
//   double-buffered duty/period registers. Software writes land in shadow
//   registers; they are copied to the active set only at the period
//   boundary, so an output never sees a half-updated period.
//   Edge-aligned (0..P, period P+1) or center-aligned (0..P..1, period 2P).
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : shadow register write bus
//   i_center_mode     : 0 = edge, 1 = center; sampled at the period boundary
//   i_ch_en           : per-channel enable, applied immediately
//   o_pwm_out         : registered PWM outputs
//   o_period_start    : one-cycle pulse in the first cycle of each period
//   o_update_pending  : a shadow write is waiting for the next boundary
module pwm_multi_shadow #(
  parameter int NUM_CH = 9,
  parameter int RES    = 16,
  parameter int AW     = $clog2(NUM_CH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pwm_multi_shadow_if.slave     bus,
  input  logic                  i_center_mode,
  input  logic [NUM_CH-1:0]     i_ch_en,
  output logic [NUM_CH-1:0]     o_pwm_out,
  output logic                  o_period_start,
  output logic                  o_update_pending
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [RES-1:0] r_cnt;
  dir_t           r_dir;
  logic           r_mode_act;
  logic [RES-1:0] r_per_act;
  logic [RES-1:0] r_per_sh;
  logic           r_period_start;
  logic           r_update_pending;

  logic [RES-1:0] w_cnt_next;
  dir_t           w_dir_next;
  logic           w_boundary;
  logic           w_wr_valid;

  // Addresses above NUM_CH are silently dropped and do not raise pending.
  assign w_wr_valid = bus.wr_en && (bus.wr_addr <= AW'(NUM_CH));

  // Counter / direction next-state and boundary detection.
  always_comb begin
    w_boundary = 1'b0;
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;

    if (r_per_act == '0) begin
      w_boundary = 1'b1;
    end else if (!r_mode_act) begin
      w_boundary = (r_cnt == r_per_act);
    end else if (r_dir == DIR_DOWN) begin
      w_boundary = (r_cnt == RES'(1));
    end else begin
      // Center mode with P==1: the top of the ramp is also the last cycle.
      w_boundary = (r_cnt == r_per_act) && (r_per_act == RES'(1));
    end

    if (w_boundary) begin
      w_cnt_next = '0;
      w_dir_next = DIR_UP;
    end else if (r_mode_act && (r_dir == DIR_DOWN)) begin
      w_cnt_next = r_cnt - RES'(1);
    end else if (r_mode_act && (r_cnt == r_per_act)) begin
      // Turn around at the top; P itself is visited only once.
      w_cnt_next = r_cnt - RES'(1);
      w_dir_next = DIR_DOWN;
    end else begin
      w_cnt_next = r_cnt + RES'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt            <= '0;
      r_dir            <= DIR_UP;
      r_mode_act       <= 1'b0;
      r_per_act        <= '1;
      r_per_sh         <= '1;
      r_period_start   <= 1'b0;
      r_update_pending <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_next;
      r_dir          <= w_dir_next;
      r_period_start <= w_boundary;
      if (w_wr_valid && (bus.wr_addr == AW'(NUM_CH))) begin
        r_per_sh <= bus.wr_data;
      end
      // Active copy takes the pre-write shadow when a write hits the boundary.
      if (w_boundary) begin
        r_per_act  <= r_per_sh;
        r_mode_act <= i_center_mode;
      end
      r_update_pending <= w_wr_valid | (r_update_pending & ~w_boundary);
    end
  end

  assign o_period_start   = r_period_start;
  assign o_update_pending = r_update_pending;

  // Per-channel duty shadow/active pair and compare.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [RES-1:0] r_duty_sh;
      logic [RES-1:0] r_duty_act;
      logic           r_pwm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_duty_sh  <= '0;
          r_duty_act <= '0;
          r_pwm      <= 1'b0;
        end else begin
          if (w_wr_valid && (bus.wr_addr == AW'(gi))) begin
            r_duty_sh <= bus.wr_data;
          end
          if (w_boundary) begin
            r_duty_act <= r_duty_sh;
          end
          // Compares against the current count, so the output lags cnt by one.
          r_pwm <= i_ch_en[gi] & (r_cnt < r_duty_act);
        end
      end

      assign o_pwm_out[gi] = r_pwm;
    end
  endgenerate

endmodule
